// File: rtl/dm_bytelane.sv
// dm_bytelane: MEM-stage data memory with lane-aligned byte/half/word stores,
// sign/zero-extended registered load result, access-error flag and write trace.
module dm_bytelane #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned IDX_W       = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        we,
  input  logic        re,
  input  logic        hold,
  input  logic [31:0] addr,
  input  logic [2:0]  wordmode,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_q,
  output logic        err_q
);

  // Access width/sign codes, matching the wm_* encoding used by the decoder.
  localparam logic [2:0] WM_WD = 3'd0;
  localparam logic [2:0] WM_HU = 3'd1;
  localparam logic [2:0] WM_HS = 3'd2;
  localparam logic [2:0] WM_BU = 3'd3;
  localparam logic [2:0] WM_BS = 3'd4;

  // First byte address past the end of the array; no aliasing above it.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;
  logic [31:0]      wlane;
  logic [31:0]      merged;
  logic [15:0]      rhalf;
  logic [7:0]       rbyte;
  logic [31:0]      extracted;
  logic             misaligned_c;
  logic             range_err_c;
  logic             mode_err_c;
  logic             err_c;
  logic             commit_c;

  assign idx   = addr[IDX_W+1:2];
  assign rword = mem[idx];

  // Error detection: misalignment, out-of-range address, undefined mode.
  always_comb begin
    misaligned_c = 1'b0;
    mode_err_c   = 1'b0;
    case (wordmode)
      WM_WD:        misaligned_c = (addr[1:0] != 2'b00);
      WM_HU, WM_HS: misaligned_c = addr[0];
      WM_BU, WM_BS: misaligned_c = 1'b0;
      default:      mode_err_c   = 1'b1;
    endcase
    range_err_c = ({1'b0, addr} >= ADDR_LIMIT);
    err_c       = misaligned_c | range_err_c | mode_err_c;
  end

  // Replicate the store datum into every lane it may occupy.
  always_comb begin
    wlane = wdata;
    case (wordmode)
      WM_HU, WM_HS: wlane = {wdata[15:0], wdata[15:0]};
      WM_BU, WM_BS: wlane = {4{wdata[7:0]}};
      default:      wlane = wdata;
    endcase
  end

  // Word as it will look after a committed store (used for write and trace).
  always_comb begin
    merged = rword;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wlane[8*i +: 8];
    end
  end

  assign commit_c = we & ~err_c;

  // Load extraction from the pre-edge contents of the addressed word.
  always_comb begin
    rhalf = addr[1] ? rword[31:16] : rword[15:0];
    case (addr[1:0])
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    case (wordmode)
      WM_WD:   extracted = rword;
      WM_HU:   extracted = {16'h0000, rhalf};
      WM_HS:   extracted = {{16{rhalf[15]}}, rhalf};
      WM_BU:   extracted = {24'h000000, rbyte};
      WM_BS:   extracted = {{24{rbyte[7]}}, rbyte};
      default: extracted = 32'h0000_0000;
    endcase
  end

  // Memory array: cleared on reset, lane-masked store on commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem[i] <= 32'h0000_0000;
      end
    end else if (commit_c) begin
      mem[idx] <= merged;
    end
  end

  // Registered load result and error flag, frozen while the pipe is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else if (!hold) begin
      rdata_q <= (re && !err_c) ? extracted : 32'h0000_0000;
      err_q   <= (re | we) & err_c;
    end
  end

`ifndef SYNTHESIS
  // Write trace for every committed store, including an empty byte mask.
  always @(posedge clk) begin
    if (!reset && commit_c) begin
      $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
    end
  end
`endif

endmodule

// File: doc/dm_bytelane.md
Name: dm_bytelane

Overview:
- Data memory for the MEM stage of the pipelined MIPS CPU.
- Sits directly downstream of the byte-enable decoder and consumes its be[3:0] together with the same wordmode/address.
- Performs lane-aligned byte/half/word stores, and registers the sign- or zero-extended load result as the value handed to the MEM/WB boundary.
- Flags misaligned and out-of-range accesses and emits the standard write trace.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words; byte address range 0 .. DEPTH_WORDS*4-1
IDX_W, 12, word-index width (log2 DEPTH_WORDS); index = addr[IDX_W+1:2]

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears memory array, rdata_q, err_q
pc  input  32  PC of the instruction in MEM, used only for the write trace
we  input  1  store request (sw/sh/sb in MEM)
re  input  1  load request (lw/lh/lhu/lb/lbu in MEM)
hold  input  1  stall; when 1, rdata_q and err_q keep their values; writes still honour we
addr  input  32  byte address (ALU result)
wordmode  input  3  access width/sign, `wm_wd/`wm_hu/`wm_hs/`wm_bu/`wm_bs from head.v
be  input  4  byte-lane enables from the decoder, lane i = bits [8i+7:8i]
wdata  input  32  unaligned store data (rt value; low byte/half holds the datum)
rdata_q  output  32  registered, extended load result
err_q  output  1  registered access-error flag for the instruction just completed

Behaviour:
- Reset (async, any time incl. mid-store): every memory word = 0, rdata_q = 0, err_q = 0. Takes effect immediately, not at next edge.
- Error detect (combinational, err_c):
  - misaligned: `wm_wd with addr[1:0]!=0; `wm_hu/`wm_hs with addr[0]!=0
  - out of range: addr >= DEPTH_WORDS*4
  - undefined wordmode code
- Lane alignment of wdata (wlane):
  - word: wdata
  - half: {wdata[15:0], wdata[15:0]}
  - byte: wdata[7:0] replicated into all four lanes
  - be selects which lanes commit.
- Store:
  - At posedge, if we=1 and err_c=0, mem[idx] lane i <= wlane lane i for each be[i]=1; other lanes unchanged.
  - we=1 with err_c=1: no write, no trace.
  - be=0000 with we=1: no change, but trace still printed.
- Trace on each committed store: $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, merged word after write).
- Load extract (combinational from mem[idx] pre-edge contents):
  - `wm_wd: whole word
  - `wm_hu: zero-extend half selected by addr[1] (0 -> [15:0], 1 -> [31:16])
  - `wm_hs: sign-extend the same half
  - `wm_bu: zero-extend byte addr[1:0]
  - `wm_bs: sign-extend the same byte
- Registered outputs at posedge, when hold=0:
  - rdata_q <= (re && !err_c) ? extracted : 0
  - err_q <= (re|we) & err_c
- Latency: store visible to a load issued the following cycle; load result valid one cycle after the access (rdata_q).
- re and we are never both 1 in one instruction. If they are, write-then-read ordering is not required: rdata_q gets the pre-write word, and the store still commits.
- hold=1: rdata_q/err_q frozen; memory still written if we=1 (the pipeline guarantees we=0 under stall).
- Address wrap: none. Indices beyond DEPTH_WORDS are errors, never aliased.

Test Plan:
- Reset mid-run -> rdata_q=0, err_q=0 immediately; a subsequent lw at 0x10 -> rdata_q=0.
- sw 0x12345678 @0x0, then sb 0xAB @0x2 (be=0100) -> trace "*00000000 <= 12AB5678"; lbu @0x2 -> 0x000000AB; lb @0x2 -> 0xFFFFFFAB.
- sh 0x8001 @0x6 (be=1100) on a zero word -> lh @0x6 = 0xFFFF8001, lhu @0x6 = 0x00008001, lw @0x4 = 0x80010000.
- sw @0x3 (misaligned) -> memory unchanged, no trace, err_q=1 next cycle; lh @0x1 -> err_q=1, rdata_q=0.
- lw @DEPTH_WORDS*4 -> err_q=1, rdata_q=0; last word @DEPTH_WORDS*4-4 reads/writes normally.
- hold=1 across two edges after lw @0x0 -> rdata_q stays 0x12AB5678; release -> next load result appears one cycle later.
